// File: rtl/maxpool_relu_stream.sv
// rtl/maxpool_relu_stream.sv - streaming 2x2/stride-2 signed max-pool with optional ReLU
// Build option: define MAXPOOL_RELU_EN to clamp negative pooled samples to zero.
module maxpool_relu_stream #(
   parameter int CONV_BIT = 12,
   parameter int CH       = 3,
   parameter int IMG_W    = 24,
   parameter int IMG_H    = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_in,
   input  logic [CH*CONV_BIT-1:0] data_in,
   output logic [CH*CONV_BIT-1:0] data_out,
   output logic                   valid_out,
   output logic                   frame_done
);

   localparam int DW      = CH * CONV_BIT;
   localparam int CW      = $clog2(IMG_W);
   localparam int RW      = $clog2(IMG_H);
   localparam int PW      = IMG_W / 2;
   localparam int AW      = (PW > 1) ? $clog2(PW) : 1;
   localparam int LAST_PR = 2 * (IMG_H / 2) - 1;
   localparam int LAST_PC = 2 * (IMG_W / 2) - 1;
   localparam bit W_ODD   = (IMG_W % 2) == 1;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [DW-1:0] hold_q, hold_d;
   logic [DW-1:0] data_out_q, data_out_d;
   logic          valid_out_q, valid_out_d;
   logic          frame_done_q, frame_done_d;

   // Line buffer holds one horizontal maximum per column pair of the last even row.
   logic [DW-1:0] lb_mem [PW];
   logic [AW-1:0] lb_addr;
   logic [DW-1:0] lb_rd;
   logic          lb_we;

   logic [DW-1:0] hmax_w;
   logic [DW-1:0] pool_w;
   logic signed [CONV_BIT-1:0] hold_s, in_s, h_s, lb_s, p_s;

   logic col_last, row_last, col_unpaired;

   assign lb_addr      = AW'(col_q >> 1);
   assign lb_rd        = lb_mem[lb_addr];
   assign col_last     = (col_q == CW'(IMG_W - 1));
   assign row_last     = (row_q == RW'(IMG_H - 1));
   // The trailing column of an odd-width frame has no partner and is dropped.
   assign col_unpaired = W_ODD && col_last;

   // Per-channel horizontal max, vertical max against the line buffer, then optional ReLU.
   always_comb begin
      hmax_w = '0;
      pool_w = '0;
      hold_s = '0;
      in_s   = '0;
      h_s    = '0;
      lb_s   = '0;
      p_s    = '0;
      for (int c = 0; c < CH; c++) begin
         hold_s = $signed(hold_q[c*CONV_BIT +: CONV_BIT]);
         in_s   = $signed(data_in[c*CONV_BIT +: CONV_BIT]);
         h_s    = (hold_s > in_s) ? hold_s : in_s;
         lb_s   = $signed(lb_rd[c*CONV_BIT +: CONV_BIT]);
         p_s    = (lb_s > h_s) ? lb_s : h_s;
`ifdef MAXPOOL_RELU_EN
         if (p_s[CONV_BIT-1]) begin
            p_s = '0;
         end
`endif
         hmax_w[c*CONV_BIT +: CONV_BIT] = h_s;
         pool_w[c*CONV_BIT +: CONV_BIT] = p_s;
      end
   end

   // Raster counters, hold capture, line-buffer write enable and output staging.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      data_out_d   = data_out_q;
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
      lb_we        = 1'b0;
      if (valid_in) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (!col_unpaired) begin
            if (!col_q[0]) begin
               hold_d = data_in;
            end else if (!row_q[0]) begin
               lb_we = 1'b1;
            end else begin
               data_out_d   = pool_w;
               valid_out_d  = 1'b1;
               frame_done_d = (row_q == RW'(LAST_PR)) && (col_q == CW'(LAST_PC));
            end
         end
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         data_out_q   <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line-buffer storage is never reset; every entry is written on an even row before use.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         lb_mem[lb_addr] <= hmax_w;
      end
   end

   assign data_out   = data_out_q;
   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// tb/tb_maxpool_relu_stream.sv - self-checking bench for maxpool_relu_stream (4x4 and 5x5 instances)
module tb_maxpool_relu_stream;

   localparam int CB = 12;
   localparam int CH = 3;
   localparam int DW = CH * CB;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]         vin = '0;
   logic [1:0][DW-1:0] din = '0;
   logic [1:0][DW-1:0] dout;
   logic [1:0]         vo;
   logic [1:0]         fd;

   maxpool_relu_stream #(.CONV_BIT(CB), .CH(CH), .IMG_W(4), .IMG_H(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .valid_in(vin[0]), .data_in(din[0]),
      .data_out(dout[0]), .valid_out(vo[0]), .frame_done(fd[0]));

   maxpool_relu_stream #(.CONV_BIT(CB), .CH(CH), .IMG_W(5), .IMG_H(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .valid_in(vin[1]), .data_in(din[1]),
      .data_out(dout[1]), .valid_out(vo[1]), .frame_done(fd[1]));

   int n_checks = 0;
   int n_fail   = 0;

   // Frame images, indexed [instance][row][col][channel].
   int img [2][5][5][3];

   // Driver-side expectation for the pixel currently presented.
   logic [1:0]         trig = '0;
   logic [1:0]         done = '0;
   logic [1:0][DW-1:0] expd = '0;

   // Expectation aligned to the cycle the DUT registers its output.
   logic [1:0]         s_trig;
   logic [1:0]         s_done;
   logic [1:0][DW-1:0] s_exp;
   logic [1:0][DW-1:0] last_data = '0;
   int                 out_cnt [2] = '{0, 0};
   logic [DW-1:0]      exp_now;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_pool(input int k, input int pr, input int pc, input int ch);
      int m;
      m = img[k][2*pr][2*pc][ch];
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++)
            if (img[k][2*pr+dr][2*pc+dc][ch] > m) m = img[k][2*pr+dr][2*pc+dc][ch];
`ifdef MAXPOOL_RELU_EN
      if (m < 0) m = 0;
`endif
      return m;
   endfunction

   function automatic logic [DW-1:0] model_pix(input int k, input int pr, input int pc);
      logic [DW-1:0] v;
      v = '0;
      for (int ch = 0; ch < CH; ch++) v[ch*CB +: CB] = CB'(model_pool(k, pr, pc, ch));
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         vin = '0;
      end
   endtask

   // Presents a frame in raster order; gaps inserted with probability (100-duty)%.
   task automatic drive_frame(input int k, input int duty, input int npix);
      int w;
      int cnt;
      w = k ? 5 : 4;
      cnt = 0;
      for (int r = 0; r < w; r++) begin
         for (int c = 0; c < w; c++) begin
            if (npix >= 0 && cnt >= npix) return;
            while ($urandom_range(1, 100) > duty) begin
               @(posedge clk); #1;
               vin[k] = 1'b0;
               din[k] = DW'({$urandom, $urandom});
            end
            @(posedge clk); #1;
            vin[k] = 1'b1;
            for (int ch = 0; ch < CH; ch++) din[k][ch*CB +: CB] = CB'(img[k][r][c][ch]);
            trig[k] = (r % 2 == 1) && (c % 2 == 1);
            expd[k] = trig[k] ? model_pix(k, r / 2, c / 2) : '0;
            done[k] = trig[k] && (r / 2 == w / 2 - 1) && (c / 2 == w / 2 - 1);
            cnt++;
         end
      end
   endtask

   // Capture what the DUT should show after this edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_trig <= '0;
         s_done <= '0;
      end else begin
         s_trig <= vin & trig;
         s_done <= done;
         s_exp  <= expd;
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         check($sformatf("valid_out[%0d]", k), DW'(vo[k]), DW'(s_trig[k]));
         check($sformatf("frame_done[%0d]", k), DW'(fd[k]), DW'(s_trig[k] & s_done[k]));
         if (!rst_n) exp_now = '0;
         else if (s_trig[k]) exp_now = s_exp[k];
         else exp_now = last_data[k];
         check($sformatf("data_out[%0d]", k), dout[k], exp_now);
         last_data[k] <= exp_now;
         if (s_trig[k]) out_cnt[k] <= out_cnt[k] + 1;
      end
   end

   task automatic fill_ramp4();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            for (int ch = 0; ch < CH; ch++) img[0][r][c][ch] = r * 4 + c;
   endtask

   task automatic fill5(input int off);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            for (int ch = 0; ch < CH; ch++)
               img[1][r][c][ch] = (r == 4 || c == 4) ? 2047 : r * 5 + c + ch + off;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      logic [DW-1:0] lit;
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               for (int ch = 0; ch < CH; ch++) img[k][r][c][ch] = 0;

      repeat (3) @(posedge clk);
      #1;
      check("reset data_out", dout[0], '0);
      check("reset valid_out", DW'(vo[0]), '0);
      check("reset frame_done", DW'(fd[0]), '0);
      rst_n = 1'b1;
      idle(2);

      // Ramp frame, continuous valid.
      fill_ramp4();
      check("model ramp p00", DW'(model_pool(0, 0, 0, 0)), DW'(5));
      check("model ramp p01", DW'(model_pool(0, 0, 1, 1)), DW'(7));
      check("model ramp p10", DW'(model_pool(0, 1, 0, 2)), DW'(13));
      check("model ramp p11", DW'(model_pool(0, 1, 1, 0)), DW'(15));
      base = out_cnt[0];
      drive_frame(0, 100, -1);
      idle(3);
      check("ramp output count", DW'(out_cnt[0] - base), DW'(4));

      // Same frame with random valid duty cycle, two frames.
      base = out_cnt[0];
      drive_frame(0, $urandom_range(30, 100), -1);
      drive_frame(0, $urandom_range(30, 100), -1);
      idle(3);
      check("gapped output count", DW'(out_cnt[0] - base), DW'(8));

      // All-negative frame.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            for (int ch = 0; ch < CH; ch++) img[0][r][c][ch] = -100 - (r * 4 + c);
`ifdef MAXPOOL_RELU_EN
      check("model neg p00", DW'(model_pool(0, 0, 0, 0)), DW'(0));
      check("model neg p11", DW'(model_pool(0, 1, 1, 0)), DW'(0));
`else
      check("model neg p00", DW'(model_pool(0, 0, 0, 0)), DW'(-100));
      check("model neg p01", DW'(model_pool(0, 0, 1, 0)), DW'(-102));
      check("model neg p10", DW'(model_pool(0, 1, 0, 0)), DW'(-108));
      check("model neg p11", DW'(model_pool(0, 1, 1, 0)), DW'(-110));
`endif
      drive_frame(0, 100, -1);
      idle(3);

      // Channel independence.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            img[0][r][c][0] = (r == 0 && c == 0) ? 500 : 0;
            img[0][r][c][1] = (r == 1 && c == 1) ? 300 : 0;
            img[0][r][c][2] = -5;
         end
`ifdef MAXPOOL_RELU_EN
      lit = {12'h000, 12'd300, 12'd500};
`else
      lit = {12'hFFB, 12'd300, 12'd500};
`endif
      check("model channel p00", model_pix(0, 0, 0), lit);
      drive_frame(0, 100, -1);
      idle(3);

      // 5x5 frames back to back; last row/column are 2047 and must never appear.
      fill5(0);
      check("model 5x5 p00", DW'(model_pool(1, 0, 0, 0)), DW'(6));
      check("model 5x5 p11", DW'(model_pool(1, 1, 1, 0)), DW'(18));
      base = out_cnt[1];
      drive_frame(1, 100, -1);
      fill5(40);
      drive_frame(1, 100, -1);
      idle(3);
      check("5x5 output count", DW'(out_cnt[1] - base), DW'(8));

      // Reset after 6 pixels, while the first pooled pixel is on the output.
      fill_ramp4();
      drive_frame(0, 100, 6);
      @(posedge clk); #1;
      vin = '0;
      check("pre-reset valid_out", DW'(vo[0]), DW'(1));
      check("pre-reset data_out", dout[0], model_pix(0, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset data_out", dout[0], '0);
      check("async reset valid_out", DW'(vo[0]), '0);
      check("async reset frame_done", DW'(fd[0]), '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = out_cnt[0];
      drive_frame(0, 100, -1);
      idle(4);
      check("post-reset output count", DW'(out_cnt[0] - base), DW'(4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
